// File: rtl/apu_recorder.sv
// -----------------------------------------------------------------------------
// apu_recorder
//
// Receive-side audio capture for the APU. The I2S bit clock, word select and
// serial data are oversampled in the system clock domain. The upper byte of
// each 16-bit left-channel word is kept, eight such bytes are packed into a
// 64-bit chunk, and chunks are written sequentially into 64-entry DRAM
// buffers handed over by the CPU through the MMIO control word.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   control[31:0]        MMIO word: [0] irq ack, [1] irq enable,
//                        [2] enqueue base, [3] capture enable, [31:9] base
//   control_valid        one-cycle strobe qualifying control
//   buf_irq              registered "no spare buffer queued" interrupt
//   i2s_sck/ws/sd        asynchronous I2S pins (ws = 0 selects left)
//   mem_wdata/mem_addr   chunk and 64-bit word address of the pending write
//   mem_write_en         write request; held with stable addr/data until ack
//   mem_ack              write accepted on a cycle where mem_write_en = 1
//   drop_count           discarded-chunk counter (0 unless built with it)
//   dbg_state            {buffer FSM in RUN, write FSM in WRITE}
//
// Handshake: a write transfers on every rising clock edge where both
// mem_write_en and mem_ack are 1; mem_addr and mem_wdata do not change while
// mem_write_en is 1 and mem_ack is 0.
//
// Build option: define APU_REC_DROP_COUNT_EN to build the saturating
// drop counter; otherwise drop_count is tied to zero.
// -----------------------------------------------------------------------------
module apu_recorder (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] control,
    input  logic        control_valid,
    output logic        buf_irq,
    input  logic        i2s_sck,
    input  logic        i2s_ws,
    input  logic        i2s_sd,
    output logic [63:0] mem_wdata,
    output logic [28:0] mem_addr,
    output logic        mem_write_en,
    input  logic        mem_ack,
    output logic [15:0] drop_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic { BUF_IDLE = 1'b0, BUF_RUN = 1'b1 } buf_state_e;
    typedef enum logic { WR_WAIT = 1'b0, WR_WRITE = 1'b1 } wr_state_e;

    logic [1:0]  sck_sync_q, sck_sync_d, ws_sync_q, ws_sync_d, sd_sync_q, sd_sync_d;
    logic        sck_prev_q, sck_prev_d, ws_prev_q, ws_prev_d;
    logic        armed_q, armed_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [55:0] chunk_q, chunk_d;
    logic        capture_en_q, capture_en_d, irq_en_q, irq_en_d, buf_irq_q, buf_irq_d;
    logic        queued_valid_q, queued_valid_d;
    logic [22:0] queued_base_q, queued_base_d, active_base_q, active_base_d;
    logic [5:0]  offset_q, offset_d;
    logic [63:0] pending_q, pending_d;
    buf_state_e  buf_state_q, buf_state_d;
    wr_state_e   wr_state_q, wr_state_d;

    logic        sck_rise, sample_valid, chunk_done, take_chunk, promote, write_ack, ctrl_ack;
    logic [7:0]  sample;
    logic [63:0] chunk_full;
    logic        ctrl_unused;

    assign ctrl_unused = ^control[8:4];
    assign ctrl_ack    = control_valid & control[0];

    // Two-flop synchronisers plus the SCK history flop used for edge detection.
    always_comb begin
        sck_sync_d = {sck_sync_q[0], i2s_sck};
        ws_sync_d  = {ws_sync_q[0], i2s_ws};
        sd_sync_d  = {sd_sync_q[0], i2s_sd};
        sck_prev_d = sck_sync_q[1];
        sck_rise   = sck_sync_q[1] & ~sck_prev_q;
    end

    // Word capture: a 1->0 WS transition seen on an SCK rise arms the word;
    // that rise carries no data, the next 16 rises shift SD in MSB first.
    always_comb begin
        ws_prev_d    = ws_prev_q;
        armed_d      = armed_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        sample_valid = 1'b0;
        if (sck_rise) begin
            ws_prev_d = ws_sync_q[1];
            if (ws_prev_q && !ws_sync_q[1]) begin
                armed_d   = 1'b1;
                bit_cnt_d = 4'd0;
                shift_d   = 16'd0;
            end else if (armed_q) begin
                shift_d = {shift_q[14:0], sd_sync_q[1]};
                if (bit_cnt_q == 4'd15) begin
                    sample_valid = 1'b1;
                    armed_d      = 1'b0;
                    bit_cnt_d    = 4'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
        end
        if (!capture_en_q) begin
            armed_d      = 1'b0;
            bit_cnt_d    = 4'd0;
            shift_d      = 16'd0;
            sample_valid = 1'b0;
        end
    end

    assign sample = shift_d[15:8];

    // Packing: bytes 0..6 accumulate in chunk_q; the eighth sample completes
    // the chunk combinationally so it can be latched the same cycle.
    always_comb begin
        chunk_d    = chunk_q;
        byte_cnt_d = byte_cnt_q;
        chunk_done = 1'b0;
        chunk_full = {sample, chunk_q};
        if (sample_valid) begin
            if (byte_cnt_q == 3'd7) begin
                chunk_done = 1'b1;
                byte_cnt_d = 3'd0;
                chunk_d    = 56'd0;
            end else begin
                chunk_d[{byte_cnt_q, 3'b000} +: 8] = sample;
                byte_cnt_d = byte_cnt_q + 3'd1;
            end
        end
        if (!capture_en_q) begin
            chunk_d    = 56'd0;
            byte_cnt_d = 3'd0;
        end
    end

    // Control word decode; irq ack takes priority over irq enable.
    always_comb begin
        capture_en_d = control_valid ? control[3] : capture_en_q;
        irq_en_d     = irq_en_q;
        if (ctrl_ack)
            irq_en_d = 1'b0;
        else if (control_valid && control[1])
            irq_en_d = 1'b1;
        buf_irq_d = ctrl_ack ? 1'b0 : (irq_en_q & ~queued_valid_q);
    end

    // Next-state logic for both FSMs and the buffer bookkeeping.
    always_comb begin
        write_ack     = (wr_state_q == WR_WRITE) & mem_ack;
        buf_state_d   = buf_state_q;
        active_base_d = active_base_q;
        offset_d      = offset_q;
        promote       = 1'b0;
        case (buf_state_q)
            BUF_IDLE: begin
                if (queued_valid_q) begin
                    promote     = 1'b1;
                    buf_state_d = BUF_RUN;
                end
            end
            BUF_RUN: begin
                if (write_ack) begin
                    offset_d = offset_q + 6'd1;
                    if (offset_q == 6'd63) begin
                        if (queued_valid_q)
                            promote = 1'b1;
                        else
                            buf_state_d = BUF_IDLE;
                    end
                end
            end
            default: buf_state_d = BUF_IDLE;
        endcase
        if (promote) begin
            active_base_d = queued_base_q;
            offset_d      = 6'd0;
        end
        // A same-cycle enqueue lands after the promotion consumed the old base.
        queued_valid_d = promote ? 1'b0 : queued_valid_q;
        queued_base_d  = queued_base_q;
        if (control_valid && control[2]) begin
            queued_valid_d = 1'b1;
            queued_base_d  = control[31:9];
        end

        take_chunk = chunk_done & (buf_state_q == BUF_RUN) & (wr_state_q == WR_WAIT);
        wr_state_d = wr_state_q;
        pending_d  = pending_q;
        case (wr_state_q)
            WR_WAIT: begin
                if (take_chunk) begin
                    pending_d  = chunk_full;
                    wr_state_d = WR_WRITE;
                end
            end
            WR_WRITE: begin
                if (mem_ack)
                    wr_state_d = WR_WAIT;
            end
            default: wr_state_d = WR_WAIT;
        endcase
    end

    // Outputs.
    always_comb begin
        mem_write_en = (wr_state_q == WR_WRITE);
        mem_addr     = {active_base_q, offset_q};
        mem_wdata    = pending_q;
        buf_irq      = buf_irq_q;
        dbg_state    = {buf_state_q == BUF_RUN, wr_state_q == WR_WRITE};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync_q     <= 2'b00;
            ws_sync_q      <= 2'b00;
            sd_sync_q      <= 2'b00;
            sck_prev_q     <= 1'b0;
            ws_prev_q      <= 1'b0;
            armed_q        <= 1'b0;
            bit_cnt_q      <= 4'd0;
            shift_q        <= 16'd0;
            byte_cnt_q     <= 3'd0;
            chunk_q        <= 56'd0;
            capture_en_q   <= 1'b0;
            irq_en_q       <= 1'b0;
            buf_irq_q      <= 1'b0;
            queued_valid_q <= 1'b0;
            queued_base_q  <= 23'd0;
            active_base_q  <= 23'd0;
            offset_q       <= 6'd0;
            pending_q      <= 64'd0;
            buf_state_q    <= BUF_IDLE;
            wr_state_q     <= WR_WAIT;
        end else begin
            sck_sync_q     <= sck_sync_d;
            ws_sync_q      <= ws_sync_d;
            sd_sync_q      <= sd_sync_d;
            sck_prev_q     <= sck_prev_d;
            ws_prev_q      <= ws_prev_d;
            armed_q        <= armed_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            byte_cnt_q     <= byte_cnt_d;
            chunk_q        <= chunk_d;
            capture_en_q   <= capture_en_d;
            irq_en_q       <= irq_en_d;
            buf_irq_q      <= buf_irq_d;
            queued_valid_q <= queued_valid_d;
            queued_base_q  <= queued_base_d;
            active_base_q  <= active_base_d;
            offset_q       <= offset_d;
            pending_q      <= pending_d;
            buf_state_q    <= buf_state_d;
            wr_state_q     <= wr_state_d;
        end
    end

`ifdef APU_REC_DROP_COUNT_EN
    // A completed chunk that was not taken by the write FSM is a drop.
    logic        drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop       = chunk_done & ~take_chunk;
        drop_cnt_d = drop_cnt_q;
        if (ctrl_ack)
            drop_cnt_d = 16'd0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            drop_cnt_q <= 16'd0;
        else
            drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_apu_recorder.sv
module tb_apu_recorder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] control = 32'd0;
    logic        control_valid = 1'b0;
    logic        buf_irq;
    logic        i2s_sck = 1'b0, i2s_ws = 1'b0, i2s_sd = 1'b0;
    logic [63:0] mem_wdata;
    logic [28:0] mem_addr;
    logic        mem_write_en;
    logic        mem_ack = 1'b0;
    logic [15:0] drop_count;
    logic [1:0]  dbg_state;

    apu_recorder dut (
        .clock(clock), .reset(reset), .control(control), .control_valid(control_valid),
        .buf_irq(buf_irq), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_ack(mem_ack), .drop_count(drop_count), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // ---------------- reference model (buffer/queue level) ----------------
    logic [92:0] exp_q[$];          // {addr, data} of every write expected
    bit          m_cap, m_irq_en, m_active, m_qvalid;
    logic [22:0] m_base, m_qbase;
    int          m_off, m_drops;

    function automatic void model_reset();
        m_cap = 0; m_irq_en = 0; m_active = 0; m_qvalid = 0;
        m_base = 0; m_qbase = 0; m_off = 0; m_drops = 0;
    endfunction

    function automatic void model_promote();
        m_base = m_qbase; m_qvalid = 0; m_off = 0; m_active = 1;
    endfunction

    function automatic void model_ctrl(input logic [31:0] cw);
        m_cap = cw[3];
        if (cw[0]) begin m_irq_en = 0; m_drops = 0; end
        else if (cw[1]) m_irq_en = 1;
        if (cw[2]) begin
            m_qbase = cw[31:9]; m_qvalid = 1;
            if (!m_active) model_promote();
        end
    endfunction

    // busy: a previous write is still unacknowledged when this chunk completes
    function automatic void model_chunk(input logic [63:0] data, input bit busy);
        logic [28:0] addr;
        if (!m_cap || !m_active || busy) begin
            if (m_drops < 65535) m_drops++;
        end else begin
            addr = 29'(m_base) * 29'd64 + 29'(m_off);
            exp_q.push_back({addr, data});
            m_off++;
            if (m_off == 64) begin
                if (m_qvalid) model_promote();
                else m_active = 0;
            end
        end
    endfunction

    function automatic logic [63:0] pack(input logic [127:0] w);
        logic [63:0] d = 64'd0;
        for (int i = 0; i < 8; i++)
            d = d + ((64'(w >> (16 * i + 8))) & 64'hFF) * (64'd1 << (8 * i));
        return d;
    endfunction

    function automatic logic [63:0] exp_drops();
`ifdef APU_REC_DROP_COUNT_EN
        return 64'(m_drops);
`else
        return 64'd0;
`endif
    endfunction

    // ---------------- write monitor / responder ----------------
    bit          ack_en = 1;
    int          cyc = 0;
    int          ack63_cyc = -1;
    int          irq_rise_cyc = -1;
    logic        irq_prev = 1'b0, we_prev = 1'b0;
    logic [28:0] held_addr = '0, last_addr = '0;
    logic [63:0] held_data = '0;

    always @(negedge clock) begin : monitor
        logic [92:0] e;
        cyc++;
        if (reset) begin
            mem_ack = 1'b0;
            we_prev = 1'b0;
        end else begin
            if (mem_write_en && !we_prev) begin
                held_addr = mem_addr;
                held_data = mem_wdata;
            end
            if (mem_write_en && ack_en && ($urandom_range(0, 2) == 0)) begin
                mem_ack = 1'b1;
                check("addr_stable", mem_addr, held_addr);
                check("data_stable", mem_wdata, held_data);
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", mem_addr, e[92:64]);
                    check("write_data", mem_wdata, e[63:0]);
                end
                last_addr = mem_addr;
                if (mem_addr[5:0] == 6'd63) ack63_cyc = cyc;
            end else begin
                mem_ack = 1'b0;
            end
            we_prev = mem_write_en && !mem_ack;
        end
        if (buf_irq && !irq_prev) irq_rise_cyc = cyc;
        irq_prev = buf_irq;
    end

    // ---------------- drivers ----------------
    task automatic sck_bit(input logic ws, input logic sd);
        i2s_ws = ws; i2s_sd = sd; i2s_sck = 1'b0;
        repeat (2) @(negedge clock);
        i2s_sck = 1'b1;
        repeat (2) @(negedge clock);
        i2s_sck = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] left, input logic [15:0] right, input int nright);
        for (int i = 0; i < nright; i++) sck_bit(1'b1, right[15 - i]);
        sck_bit(1'b0, 1'($urandom_range(0, 1)));   // arming rise carries no data
        for (int i = 0; i < 16; i++) sck_bit(1'b0, left[15 - i]);
    endtask

    task automatic send_chunk(input logic [127:0] words, input logic [63:0] data,
                              input bit busy, input int nright, input logic [15:0] right);
        model_chunk(data, busy);
        for (int i = 0; i < 8; i++) send_word(words[16 * i +: 16], right, nright);
    endtask

    task automatic ctrl(input logic [31:0] cw);
        model_ctrl(cw);
        control = cw; control_valid = 1'b1;
        @(negedge clock);
        control_valid = 1'b0; control = 32'd0;
        repeat (3) @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("drain_writes", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [127:0] rand_words();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct packed {
        logic [127:0] words;   // word i at [16*i +: 16]
        logic [63:0]  exp_data;
    } vec_t;
    vec_t tbl[4];

    initial begin : watchdog
        repeat (95000) @(posedge clock);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [127:0] w;
        logic [22:0]  base;

        tbl[0] = '{words: {16'h8800, 16'h7700, 16'h6600, 16'h5500, 16'h4400, 16'h3300, 16'h2200, 16'h1100},
                   exp_data: 64'h8877665544332211};
        tbl[1] = '{words: {16'hC3C3, 16'h5A5A, 16'h7FFE, 16'h8001, 16'h00FF, 16'hFF00, 16'h1234, 16'hABCD},
                   exp_data: 64'hC35A7F8000FF12AB};
        tbl[2] = '{words: {8{16'h00FF}}, exp_data: 64'h0};
        tbl[3] = '{words: {16'h4000, 16'h9999, 16'hE0FF, 16'h0001, 16'h2011, 16'h1000, 16'hFE7F, 16'h0180},
                   exp_data: 64'h4099E0002010FE01};

        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_buf_irq", buf_irq, 0);
        check("rst_write_en", mem_write_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_fsm_state", dbg_state, 0);

        // Buffer 0x100, table-driven chunks
        ctrl({23'h000100, 9'h00E});
        for (int i = 0; i < 4; i++) begin
            send_chunk(tbl[i].words, tbl[i].exp_data, 0, $urandom_range(1, 3), 16'($urandom));
            drain();
        end
        check("irq_after_promote", buf_irq, 1);

        // Queue second buffer and fill the first one to offset 63
        ctrl({23'h000200, 9'h00E});
        check("irq_with_queued", buf_irq, 0);
        for (int i = 0; i < 61; i++) begin
            w = rand_words();
            send_chunk(w, pack(w), 0, $urandom_range(1, 3), 16'($urandom));
        end
        drain();
        check("write65_addr", last_addr, 29'h0008000);
        check("irq_rise_latency", 64'(irq_rise_cyc - ack63_cyc), 64'd2);
        check("irq_after_consume", buf_irq, 1);

        // Hold ack: second chunk completes during WRITE and is dropped
        ack_en = 0;
        w = rand_words();
        send_chunk(w, pack(w), 0, 2, 16'h0);
        repeat (8) @(negedge clock);
        check("held_write_en", mem_write_en, 1);
        w = rand_words();
        send_chunk(w, pack(w), 1, 2, 16'h0);
        repeat (8) @(negedge clock);
        check("held_addr", mem_addr, exp_q[0][92:64]);
        check("held_data", mem_wdata, exp_q[0][63:0]);
        check("drop_while_busy", drop_count, exp_drops());
        ack_en = 1;
        drain();
        w = rand_words();
        send_chunk(w, pack(w), 0, 1, 16'h0);
        drain();

        // Full 16-bit right words of all ones, left words zero
        send_chunk(128'd0, 64'h0, 0, 16, 16'hFFFF);
        drain();

        // Disable mid-chunk: partial chunk must be discarded
        for (int i = 0; i < 4; i++) send_word(16'hEE00, 16'h0, 1);
        ctrl(32'h0000_0002);
        ctrl(32'h0000_000A);
        send_chunk(tbl[0].words, tbl[0].exp_data, 0, 1, 16'h0);
        drain();

        // Reset while a write is pending
        ack_en = 0;
        w = rand_words();
        send_chunk(w, pack(w), 0, 1, 16'h0);
        repeat (8) @(negedge clock);
        check("pre_reset_write_en", mem_write_en, 1);
        reset = 1'b1;
        @(negedge clock);
        check("reset_write_en", mem_write_en, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_wdata", mem_wdata, 0);
        check("reset_buf_irq", buf_irq, 0);
        check("reset_drop_count", drop_count, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        model_reset();
        ack_en = 1;
        @(negedge clock);

        // No buffer queued: every chunk dropped, irq requests a buffer
        ctrl(32'h0000_000A);
        check("irq_no_buffer", buf_irq, 1);
        for (int i = 0; i < 2; i++) begin
            w = rand_words();
            send_chunk(w, pack(w), 0, 1, 16'($urandom));
        end
        repeat (10) @(negedge clock);
        check("idle_write_en", mem_write_en, 0);
        check("idle_drop_count", drop_count, exp_drops());
        ctrl(32'h0000_000B);   // ack + enable together: ack wins
        check("ack_clears_irq", buf_irq, 0);
        check("ack_clears_drops", drop_count, exp_drops());

        // Randomized buffers and chunks against the model
        for (int r = 0; r < 3; r++) begin
            base = 23'($urandom);
            ctrl({base, 9'h00E});
            check("rand_irq", buf_irq, 1'(m_irq_en & ~m_qvalid));
            for (int i = 0; i < 2; i++) begin
                w = rand_words();
                send_chunk(w, pack(w), 0, $urandom_range(1, 16), 16'($urandom));
            end
            drain();
        end
        repeat (10) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apu_recorder.md
# apu_recorder

Audio capture path for the APU: the receive-side counterpart of the playback engine. It oversamples an external I2S microphone/line interface in the system clock domain, keeps the upper 8 bits of each left-channel 16-bit word, packs eight samples into a 64-bit chunk and writes chunks sequentially into DRAM buffers supplied by the CPU. When no spare buffer is queued, it raises an interrupt so the CPU can supply the next buffer, using the same control-word scheme as playback.

## Interface
- Parameters: none.
- clock  input  1  system clock (50 MHz); I2S inputs are oversampled on it.
- reset  input  1  synchronous, active-high reset.
- control  input  32  MMIO control word: [0] irq ack, [1] irq enable, [2] enqueue base, [3] capture enable, [31:9] buffer base.
- control_valid  input  1  control word valid, one-cycle pulse.
- buf_irq  output  1  buffer request interrupt (registered).
- i2s_sck  input  1  external bit clock, asynchronous.
- i2s_ws  input  1  external word select, asynchronous (0 = left).
- i2s_sd  input  1  external serial data, asynchronous.
- mem_wdata  output  64  chunk to write.
- mem_addr  output  29  64-bit word address.
- mem_write_en  output  1  write request, held until ack.
- mem_ack  input  1  write accepted.
- drop_count  output  16  dropped-chunk counter (see Configuration).

## Operation
- Synchronisers: i2s_sck, i2s_ws and i2s_sd each pass through two flops. An SCK rise is a cycle where the synchronised SCK is 1 and its previous value was 0. All I2S logic acts only on SCK-rise cycles.
- Word capture: the first SCK rise at which WS reads 0 after reading 1 arms the capture. The next 16 rises shift SD into a 16-bit register, MSB first. After the 16th bit, sample = shift[15:8]. Right-channel words are ignored. A new 1→0 WS edge before 16 bits restarts the capture.
- Packing: samples fill the chunk from byte 0 (bits [7:0]) upward. After 8 samples the chunk is complete.
- Control decode on control_valid:
  - capture_en <= control[3].
  - irq ack (bit 0) clears irq_en; otherwise irq enable (bit 1) sets it.
  - Enqueue (bit 2) loads queued_base = control[31:9] and sets queued_valid.
  - Without control_valid, all control state holds.
- buf_irq next value = 0 if irq ack, else irq_en & ~queued_valid.
- Buffer FSM:
  - IDLE: no active buffer. When queued_valid, load active_base from queued_base, clear offset[5:0], clear queued_valid, then go to RUN.
  - RUN: writes go to mem_addr = {active_base, offset}. After the ack for offset 63, promote the queued buffer if valid (stay in RUN); otherwise go to IDLE.
- Write FSM:
  - WAIT: a completed chunk, when in RUN, is latched into the pending register and the FSM moves to WRITE.
  - WRITE: mem_write_en = 1 with mem_addr and mem_wdata stable until mem_ack. On ack, offset++ and return to WAIT.
- Drops: a chunk completing while in WRITE, while in IDLE, or while capture_en = 0 is discarded.
- Disabling capture clears the shift state and the partial chunk. An in-flight write completes. Buffers are retained.

## Timing
- Reset values: buf_irq 0, mem_write_en 0, mem_addr 0, mem_wdata 0, drop_count 0. Internally: capture_en 0, irq_en 0, queued_valid 0, buffer FSM IDLE, write FSM WAIT.
- Input latency: an I2S pin change affects logic 3 cycles later (2 synchroniser flops plus the edge register).
- mem_write_en rises the cycle after the chunk-complete cycle. It may be acked in the same cycle it rises; the earliest next write is the following cycle.
- Enqueue and IDLE promotion in the same cycle: the old queued_base is promoted, and the new base becomes queued with queued_valid = 1.
- Enqueue while queued_valid = 1 overwrites the queued base.
- Irq ack and irq enable in the same word: ack wins.
- Reset mid-write drops mem_write_en the next cycle. DRAM may hold a partially written buffer.

## Configuration
- APU_REC_DROP_COUNT_EN defined: drop_count increments by 1 per discarded chunk, saturating at 16'hFFFF. A control write with bit 0 set also clears it.
- Not defined: drop_count is tied to 0 and no counter logic is built.

## Test plan
- Enqueue base 23'h000100, enable capture, drive 8 left words 16'h1100, 16'h2200 … 16'h8800 -> one write, mem_addr = 29'h0004000, mem_wdata = 64'h8877665544332211.
- 64 chunks into one buffer with second base 23'h000200 queued -> 65th write at 29'h0008000; buf_irq rises 1 cycle after the queued base is consumed (irq_en set).
- Hold mem_ack low across the next chunk completion -> that chunk is dropped, drop_count = 1 (macro defined) / 0 (undefined), offset advances only by 1.
- Right-channel words 16'hFFFF interleaved with left 16'h0000 -> every written byte = 8'h00.
- No buffer queued, capture enabled -> no mem_write_en; drop_count increments per 8 samples.
- Reset asserted while in WRITE -> mem_write_en = 0 next cycle; all outputs at reset values.
